// File: rtl/hare_scheduler.sv
// rtl/hare_scheduler.sv - round-robin front end for hare_compute with periodic rebirth insertion
// Grants one requester at a time, waits LAT cycles for the datapath, and returns the tagged result.
module hare_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int LAT            = 1,
  parameter int REBIRTH_PERIOD = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          hc_data_in,
  output logic                       hc_trigger_rebirth,
  input  logic [DATA_W-1:0]          hc_data_out,
  input  logic                       hc_rebirth_active,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       rsp_ready,
  output logic                       busy,
  output logic [15:0]                rebirth_count,
  output logic                       rebirth_err
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TMR_W = (REBIRTH_PERIOD > 1) ? $clog2(REBIRTH_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_grant, grant_idx, cand;
  logic             grant_found, do_grant, start_rebirth;
  logic             op_rebirth, rebirth_pending, timer_wrap;
  logic             wait_done, wait_first;
  logic [3:0]       wait_cnt;
  logic [TMR_W-1:0] timer;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign wait_done  = (wait_cnt == 4'd0);
  assign wait_first = (wait_cnt == 4'(LAT - 1));

  always_comb begin
    state_nxt     = state;
    do_grant      = 1'b0;
    start_rebirth = 1'b0;
    case (state)
      S_IDLE: begin
        if (rebirth_pending) begin
          start_rebirth = 1'b1;
          state_nxt     = S_ISSUE;
        end else if (grant_found && rst_n) begin
          do_grant  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_done) state_nxt = op_rebirth ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= ID_W'(NUM_REQ - 1);
      op_rebirth    <= 1'b0;
      wait_cnt      <= 4'd0;
      hc_data_in    <= '0;
      rsp_id        <= '0;
      rsp_data      <= '0;
      rebirth_count <= 16'd0;
      rebirth_err   <= 1'b0;
    end else begin
      if (do_grant) begin
        hc_data_in <= DATA_W'(req_data >> (grant_idx * DATA_W));
        rsp_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == S_IDLE) op_rebirth <= start_rebirth;
      if (state == S_ISSUE) wait_cnt <= 4'(LAT - 1);
      else if (state == S_WAIT && !wait_done) wait_cnt <= wait_cnt - 4'd1;
      if (state == S_WAIT && wait_done) begin
        if (op_rebirth) begin
          if (rebirth_count != 16'hFFFF) rebirth_count <= rebirth_count + 16'd1;
        end else begin
          rsp_data <= hc_data_out;
        end
      end
      // The datapath acknowledges a rebirth one cycle after the trigger.
      if (state == S_WAIT && op_rebirth && wait_first && !hc_rebirth_active) rebirth_err <= 1'b1;
    end
  end

  assign timer_wrap = (REBIRTH_PERIOD != 0) && (timer == TMR_W'(REBIRTH_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer           <= '0;
      rebirth_pending <= 1'b0;
    end else begin
      if (timer_wrap || REBIRTH_PERIOD == 0) timer <= '0;
      else                                   timer <= timer + TMR_W'(1);
      if (state == S_ISSUE && op_rebirth) rebirth_pending <= 1'b0;
      else if (timer_wrap)                rebirth_pending <= 1'b1;
    end
  end

  assign req_ready          = do_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign hc_trigger_rebirth = (state == S_ISSUE) && op_rebirth;
  assign rsp_valid          = (state == S_RESP);
  assign busy               = (state != S_IDLE);

endmodule

// File: tb/tb_hare_scheduler.sv
// tb/tb_hare_scheduler.sv - randomized scoreboard bench for hare_scheduler
// Cycle-count reference model predicts grants and rebirths; a monitor checks responses from a queue.
module tb_hare_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LAT     = 3;
  localparam int PERIOD  = 20;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         hc_data_in, hc_data_out, rsp_data;
  logic                      hc_trigger_rebirth, hc_rebirth_active;
  logic                      rsp_valid, busy, rebirth_err;
  logic                      rsp_ready = 1'b0;
  logic [ID_W-1:0]           rsp_id;
  logic [15:0]               rebirth_count;

  always #5 clk = ~clk;

  hare_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LAT(LAT), .REBIRTH_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .hc_data_in(hc_data_in), .hc_trigger_rebirth(hc_trigger_rebirth),
    .hc_data_out(hc_data_out), .hc_rebirth_active(hc_rebirth_active),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .rebirth_count(rebirth_count), .rebirth_err(rebirth_err)
  );

  // Datapath stub: data_in+1 through LAT stages, one-cycle rebirth acknowledge.
  logic [DATA_W-1:0] stage [LAT];
  bit stub_rb_en = 1'b1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_rebirth_active <= 1'b0;
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      hc_rebirth_active <= hc_trigger_rebirth & stub_rb_en;
      stage[0] <= hc_data_in + DATA_W'(1);
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end
  assign hc_data_out = stage[LAT-1];

  typedef struct { int id; logic [DATA_W-1:0] data; int start; } exp_t;
  exp_t sb_q[$];
  int checks = 0, errors = 0;
  int cur_cyc = 0;
  bit mon_en = 1'b0;
  bit started = 1'b0;

  int m_busy_until, m_rsp_start, m_trig_cyc, m_inc_cyc, m_clear_cyc, m_errchk_cyc;
  int m_last, m_count, c, last_grant_cyc;
  bit m_rsp_pending, m_pend, m_err, m_rb_ok;
  logic [DATA_W-1:0] m_din;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy_until = 0; m_rsp_start = 0; m_rsp_pending = 1'b0;
    m_trig_cyc = -1; m_inc_cyc = -1; m_clear_cyc = -1; m_errchk_cyc = -1;
    m_last = NUM_REQ - 1; m_count = 0; m_pend = 1'b0; m_err = 1'b0; m_rb_ok = 1'b1;
    m_din = '0; c = 0; last_grant_cyc = -1;
    sb_q.delete(); started = 1'b0;
  endtask

  // Evaluate cycle c from the timeline: busy windows, pending flag and grant rotation.
  task automatic step();
    bit idle;
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    logic [DATA_W-1:0] d;
    idle = (c >= m_busy_until) && !m_rsp_pending;
    exp_ready = '0;
    chk("busy", 64'(busy), 64'(!idle));
    chk("trigger", 64'(hc_trigger_rebirth), 64'(c == m_trig_cyc));
    chk("rebirth_count", 64'(rebirth_count), 64'(m_count));
    chk("rebirth_err", 64'(rebirth_err), 64'(m_err));
    chk("hc_data_in", 64'(hc_data_in), 64'(m_din));
    if (c == m_trig_cyc) m_rb_ok = stub_rb_en;
    if (idle) begin
      if (m_pend) begin
        m_trig_cyc = c + 1; m_clear_cyc = c + 1; m_errchk_cyc = c + 2;
        m_inc_cyc = c + 1 + LAT; m_busy_until = c + LAT + 2;
      end else begin
        g = -1;
        for (int k = 1; k <= NUM_REQ && g < 0; k++) begin
          int idx;
          idx = (m_last + k) % NUM_REQ;
          if (req_valid[idx[ID_W-1:0]]) g = idx;
        end
        if (g >= 0) begin
          d = DATA_W'(req_data >> (g * DATA_W));
          exp_ready = NUM_REQ'(1) << g;
          sb_q.push_back('{id: g, data: d + DATA_W'(1), start: c + 2 + LAT});
          m_rsp_pending = 1'b1; m_rsp_start = c + 2 + LAT; m_busy_until = c + 2 + LAT;
          m_last = g; m_din = d; last_grant_cyc = c;
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (m_rsp_pending && c >= m_rsp_start && rsp_ready) begin
      m_rsp_pending = 1'b0;
      m_busy_until = c + 1;
    end
    if (c == m_errchk_cyc && !m_rb_ok) m_err = 1'b1;
    if (c == m_inc_cyc && m_count < 65535) m_count++;
    if (c == m_clear_cyc) m_pend = 1'b0;
    else if (PERIOD != 0 && (c % PERIOD) == PERIOD - 1) m_pend = 1'b1;
    c++;
  endtask

  always @(negedge clk) begin
    if (mon_en && rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        if (!started) begin
          chk("rsp_latency", 64'(cur_cyc), 64'(sb_q[0].start));
          started = 1'b1;
        end
        chk("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
        if (rsp_ready) begin
          void'(sb_q.pop_front());
          started = 1'b0;
        end
      end
    end
  end

  task automatic cycle(input logic [NUM_REQ-1:0] v, input bit rdy);
    req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = $urandom;
    rsp_ready = rdy;
    cur_cyc = c;
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input int n, input int p_valid, input int p_ready);
    logic [NUM_REQ-1:0] v;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < NUM_REQ; b++) v[b] = ($urandom_range(99) < p_valid);
      cycle(v, $urandom_range(99) < p_ready);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_hc_data_in"}, 64'(hc_data_in), 64'(0));
    chk({tag, "_trigger"}, 64'(hc_trigger_rebirth), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_rebirth_count"}, 64'(rebirth_count), 64'(0));
    chk({tag, "_rebirth_err"}, 64'(rebirth_err), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_phase(200, 100, 100);
    run_phase(600, 30, 50);
    run_phase(300, 100, 5);
    run_phase(200, 0, 100);
    stub_rb_en = 1'b0;
    run_phase(200, 20, 70);
    stub_rb_en = 1'b1;
    run_phase(40, 0, 100);

    // Reset during the WAIT phase of a fresh request.
    last_grant_cyc = -1;
    for (int i = 0; i < 100 && last_grant_cyc < 0; i++) cycle(4'b0001, 1'b1);
    chk("grant_before_reset", 64'(last_grant_cyc >= 0), 64'(1));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    chk("busy_in_wait", 64'(busy), 64'(1));
    mon_en = 1'b0;
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midop");
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_phase(600, 60, 60);
    run_phase(60, 0, 100);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hare_scheduler.md
# hare_scheduler

- Round-robin scheduler that shares one `hare_compute` datapath between `NUM_REQ` requesters.
- Sequences each accepted request through issue, wait and response phases, and returns the result tagged with the requester id.
- Autonomously inserts periodic Phoenix rebirth operations (`trigger_rebirth`) and counts them.
- Sits directly in front of `hare_compute`; this block is the only driver of its `data_in` and `trigger_rebirth`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: datapath width.
- `LAT`, 1: datapath latency in cycles, 1..15; `hc_data_out` is valid at the end of the `LAT`-th cycle after the ISSUE cycle.
- `REBIRTH_PERIOD`, 256: cycles between rebirth requests; 0 disables rebirth.
- `clk` in 1: clock. One clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: request valid, one bit per requester.
- `req_data` in `NUM_REQ*DATA_W`: requester i's operand at `[i*DATA_W +: DATA_W]`.
- `req_ready` out `NUM_REQ`: one-hot accept strobe.
- `hc_data_in` out `DATA_W`: to `hare_compute.data_in`.
- `hc_trigger_rebirth` out 1: to `hare_compute.trigger_rebirth`.
- `hc_data_out` in `DATA_W`: from `hare_compute.data_out`.
- `hc_rebirth_active` in 1: from `hare_compute.rebirth_active`.
- `rsp_valid` out 1: response valid.
- `rsp_id` out `$clog2(NUM_REQ)`: requester index of the response.
- `rsp_data` out `DATA_W`: captured result.
- `rsp_ready` in 1: response sink ready.
- `busy` out 1: high whenever state is not IDLE.
- `rebirth_count` out 16: completed rebirths, saturating at 16'hFFFF.
- `rebirth_err` out 1: sticky flag, set if `hc_rebirth_active` is not seen after a rebirth issue.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If `rebirth_pending` is set: go to ISSUE with `op_rebirth=1`. Rebirth has priority over all requests.
  - Else if any `req_valid` bit is set: grant by round-robin, searching from `last_grant+1` modulo `NUM_REQ`.
    - `req_ready[g]` is high combinationally in this cycle only.
    - At the clock edge: `hc_data_in<=req_data[g]`, `rsp_id<=g`, `last_grant<=g`, go to ISSUE with `op_rebirth=0`.
- **ISSUE (exactly 1 cycle):**
  - `hc_trigger_rebirth` equals `op_rebirth`.
  - If `op_rebirth=1`, clear `rebirth_pending`.
  - Load `wait_cnt<=LAT-1`, go to WAIT.
- **WAIT:**
  - Decrement `wait_cnt` each cycle.
  - At the edge where `wait_cnt==0`:
    - Request op: `rsp_data<=hc_data_out`, go to RESP.
    - Rebirth op: increment `rebirth_count` (saturating), go to IDLE.
  - Rebirth ops check `hc_rebirth_active` at the end of the first WAIT cycle; if it is 0, set `rebirth_err`.
- **RESP:**
  - `rsp_valid=1`; `rsp_id` and `rsp_data` hold stable.
  - When `rsp_valid && rsp_ready` at the edge, go to IDLE.
- **Datapath drive:**
  - `hc_trigger_rebirth` is 0 outside ISSUE.
  - `hc_data_in` holds its last value outside grants, so the datapath output stays stable.
- **Rebirth timer:**
  - Free-running counter, 0..`REBIRTH_PERIOD-1`.
  - At wrap, set `rebirth_pending`.
  - A wrap while already pending does nothing; there is no queueing.
  - The timer keeps counting in every state.
- **Arithmetic:** no arithmetic on data; `rsp_data` is a pure capture.
- **Reset values:**
  - `req_ready=0`, `hc_data_in=0`, `hc_trigger_rebirth=0`.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`.
  - `busy=0`, `rebirth_count=0`, `rebirth_err=0`.
  - `last_grant=NUM_REQ-1`, so requester 0 wins first.
  - Timer 0, pending 0, state IDLE.
- **Reset mid-operation:** any in-flight op is dropped with no response, and all state returns to reset values.

## Timing
- Request accepted in cycle t (IDLE, `req_ready` high).
- ISSUE occupies cycle t+1.
- WAIT occupies cycles t+2..t+1+`LAT`.
- `rsp_valid` rises in cycle t+2+`LAT`, so accept-to-response latency is `LAT+2`.
- Back-to-back throughput: one op per `LAT+3` cycles when `rsp_ready` is held high.
- A rebirth occupies the datapath for `LAT+1` cycles and then returns to IDLE; the next grant can come one cycle later.
- The timer wrap and a request arriving in the same IDLE cycle: the wrap only sets pending, and the request is granted in that cycle. The rebirth goes next.
- `req_valid` deasserting while not granted is allowed; the requester simply loses its turn.

## Test plan
Datapath stub for all scenarios: returns `data_in+1` after `LAT`, and asserts `rebirth_active` for one cycle after a trigger. Use `LAT=1` unless stated.
- Single request: `req_valid=4'b0001`, data 0x10, `REBIRTH_PERIOD=0` -> `req_ready=0001`; `rsp_valid` 3 cycles later with id 0, data 0x11, held until `rsp_ready`.
- Round-robin: all four requesters valid continuously, `rsp_ready=1` -> grant order 0,1,2,3,0; each grant 4 cycles apart.
- Backpressure: `rsp_ready=0` for 10 cycles -> `rsp_valid`, `rsp_id` and `rsp_data` stable; no new `req_ready`; `busy=1`.
- Rebirth: `REBIRTH_PERIOD=8`, no requests -> `hc_trigger_rebirth` pulses 1 cycle in every 8; `rebirth_count` reaches 3 after 3 pulses; `rebirth_err=0`. With the stub's `rebirth_active` disabled -> `rebirth_err=1` and stays 1.
- Collision: timer wrap in the same cycle a requester is valid -> request granted first; rebirth issued right after the response completes; `LAT=3` gives response latency 5.
- Reset: assert `rst_n=0` during WAIT -> all outputs return to reset values immediately; after release, requester 0 wins first and no stale response appears.
